parity_rx: RTL

Serial frame receiver with XOR parity checking. It is the receive end of the parity-protected serial link whose transmitter computes parity as the XOR of all data bits. Each frame is start bit, DATA_W data bits LSB first, one parity bit, then a stop bit. The block sits between the bit-timing generator, which supplies `bit_en`, and the parallel consumer logic.

---
 rtl/parity_rx_pkg.sv | 17 +
 rtl/parity_acc.sv | 25 ++
 rtl/parity_rx.sv | 132 +++++++++++++
 3 files changed

// File: rtl/parity_rx_pkg.sv
// Shared types and constants for the parity-protected serial receiver.
package parity_rx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StData,
        StParity,
        StStop,
        StWaitHi
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int unsigned ERR_CNT_W = 8;

endpackage

// File: rtl/parity_acc.sv
// Running one-bit XOR accumulator; shared by the parity transmitter and receiver.
module parity_acc (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic bit_in,
    output logic acc
);

    logic acc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= 1'b0;
        end else if (clr) begin
            acc_q <= 1'b0;
        end else if (en) begin
            acc_q <= acc_q ^ bit_in;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/parity_rx.sv
// Serial frame receiver: start, DATA_W data bits LSB first, parity, stop.
// Optional saturating error counter enabled by defining PARITY_RX_ERRCNT_EN.
module parity_rx
    import parity_rx_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter logic        ODD    = PAR_EVEN
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 bit_en,
`ifdef PARITY_RX_ERRCNT_EN
    input  logic                 err_clr,
    output logic [ERR_CNT_W-1:0] err_cnt,
`endif
    output logic [DATA_W-1:0]    data_out,
    output logic                 valid,
    output logic                 par_err,
    output logic                 frm_err
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);
    localparam int unsigned IDX_W = $clog2(DATA_W);

    rx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              acc_clr, acc_en, acc;
    logic              frame_done;
    logic              frame_par_err, frame_frm_err;

    parity_acc u_acc (
        .clk    (clk),
        .rst    (rst),
        .clr    (acc_clr),
        .en     (acc_en),
        .bit_in (rx),
        .acc    (acc)
    );

    // acc already holds data and parity bits once the stop bit is sampled
    assign frame_par_err = acc ^ ODD;
    assign frame_frm_err = ~rx;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        acc_clr    = 1'b0;
        acc_en     = 1'b0;
        frame_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bit_en && !rx) begin
                    state_d = StData;
                    cnt_d   = '0;
                    acc_clr = 1'b1;
                end
            end
            StData: begin
                if (bit_en) begin
                    shift_d[cnt_q[IDX_W-1:0]] = rx;
                    acc_en = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d = StParity;
                    end
                end
            end
            StParity: begin
                if (bit_en) begin
                    acc_en  = 1'b1;
                    state_d = StStop;
                end
            end
            StStop: begin
                if (bit_en) begin
                    frame_done = 1'b1;
                    state_d    = rx ? StIdle : StWaitHi;
                end
            end
            StWaitHi: begin
                // Keep a stuck-low line or break from looking like fresh start bits
                if (bit_en && rx) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            shift_q  <= '0;
            data_out <= '0;
            valid    <= 1'b0;
            par_err  <= 1'b0;
            frm_err  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            valid   <= frame_done;
            if (frame_done) begin
                data_out <= shift_q;
                par_err  <= frame_par_err;
                frm_err  <= frame_frm_err;
            end
        end
    end

`ifdef PARITY_RX_ERRCNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q;

    // Clear wins over a coinciding error frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (err_clr) begin
            err_cnt_q <= '0;
        end else if (frame_done && (frame_par_err || frame_frm_err) && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule
